// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader.
// Receives a header byte N followed by N three-byte little-endian words over
// a valid/ready byte link. Each word is written to instruction memory through
// a one-cycle strobe. core_run is released once the image is complete.
// Malformed images latch load_error, and the core is never released.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN. When it is defined, a
// trailing checksum byte is required and the image is accepted only when
// (sum of all bytes + C) mod 256 == 0.
module imem_loader #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned INSTR_W = 19
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               core_run,
  output logic               load_error,
  output logic [ADDR_W:0]    word_count
);

  typedef enum logic [2:0] {
    S_HDR,
    S_B0,
    S_B1,
    S_B2,
    S_CHK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t          state;
  logic [ADDR_W:0] n_words;
  logic [7:0]      b0;
  logic [7:0]      b1;
  logic            hs;
  logic            last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      sum;
`endif

  // Handshake and last-word detection (word_count holds the index of the word being completed)
  always_comb begin
    hs        = rx_valid && rx_ready;
    last_word = ((word_count + (ADDR_W+1)'(1)) == n_words);
  end

  // Loader FSM with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_HDR;
      n_words    <= '0;
      b0         <= '0;
      b1         <= '0;
      rx_ready   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_run   <= 1'b0;
      load_error <= 1'b0;
      word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      // Without a checksum, release happens one cycle after the last write strobe
      if (state == S_DONE) begin
        core_run <= 1'b1;
      end
      if (hs) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum <= sum + rx_data;
`endif
        case (state)
          S_HDR: begin
            if ((rx_data == 8'h00) || (rx_data > 8'(DEPTH))) begin
              state      <= S_ERROR;
              load_error <= 1'b1;
              rx_ready   <= 1'b0;
            end else begin
              n_words <= rx_data[ADDR_W:0];
              state   <= S_B0;
            end
          end
          S_B0: begin
            b0    <= rx_data;
            state <= S_B1;
          end
          S_B1: begin
            b1    <= rx_data;
            state <= S_B2;
          end
          S_B2: begin
            imem_we    <= 1'b1;
            imem_addr  <= word_count[ADDR_W-1:0];
            imem_wdata <= INSTR_W'({rx_data, b1, b0});
            word_count <= word_count + (ADDR_W+1)'(1);
            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state    <= S_CHK;
`else
              state    <= S_DONE;
              rx_ready <= 1'b0;
`endif
            end else begin
              state <= S_B0;
            end
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          S_CHK: begin
            rx_ready <= 1'b0;
            if (8'(sum + rx_data) == 8'h00) begin
              state    <= S_DONE;
              core_run <= 1'b1;
            end else begin
              state      <= S_ERROR;
              load_error <= 1'b1;
            end
          end
`endif
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Table-driven bench for imem_loader. Each row drives one clock cycle of
// rx_valid/rx_data and lists the outputs expected just after that edge.
// Also exercises the IMEM_LOADER_CHECKSUM_EN build when that macro is defined.
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [3:0]  imem_addr;
  logic [18:0] imem_wdata;
  logic        core_run;
  logic        load_error;
  logic [4:0]  word_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        valid;
    logic [7:0]  data;
    logic [31:0] exp;   // {we, addr, wdata, ready, run, err, count}
  } vec_t;

  vec_t tbl[$];

  imem_loader #(.DEPTH(16), .ADDR_W(4), .INSTR_W(19)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_run   (core_run),
    .load_error (load_error),
    .word_count (word_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] outs();
    return {imem_we, imem_addr, imem_wdata, rx_ready, core_run, load_error, word_count};
  endfunction

  function automatic void add(logic v, logic [7:0] d, logic we, logic [3:0] a,
                              logic [18:0] wd, logic rdy, logic run, logic err,
                              logic [4:0] cnt);
    vec_t r;
    r.valid = v;
    r.data  = d;
    r.exp   = {we, a, wd, rdy, run, err, cnt};
    tbl.push_back(r);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual={we,addr,wdata,rdy,run,err,cnt}=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_table(string name);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rx_valid = tbl[i].valid;
      rx_data  = tbl[i].data;
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", name, i), outs(), tbl[i].exp);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tbl.delete();
  endtask

  task automatic do_reset(string name);
    @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b0;
    #2;
    check(name, outs(), {1'b0, 4'h0, 19'h0, 1'b1, 1'b0, 1'b0, 5'd0});
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Two-word image: 0x02 | 34 12 05 | FF FF 07 (+ optional checksum byte c)
  task automatic build_two_word(logic [7:0] c, logic ok);
    logic run_f;
    logic err_f;
    run_f = CK ? ok : 1'b1;
    err_f = CK ? !ok : 1'b0;
    add(1, 8'h02, 0, 4'd0, 19'h00000, 1, 0, 0, 5'd0);
    add(1, 8'h34, 0, 4'd0, 19'h00000, 1, 0, 0, 5'd0);
    add(1, 8'h12, 0, 4'd0, 19'h00000, 1, 0, 0, 5'd0);
    add(1, 8'h05, 1, 4'd0, 19'h51234, 1, 0, 0, 5'd1);
    add(1, 8'hFF, 0, 4'd0, 19'h51234, 1, 0, 0, 5'd1);
    add(1, 8'hFF, 0, 4'd0, 19'h51234, 1, 0, 0, 5'd1);
    add(1, 8'h07, 1, 4'd1, 19'h7FFFF, CK, 0, 0, 5'd2);
    if (CK) add(1, c, 0, 4'd1, 19'h7FFFF, 0, ok, !ok, 5'd2);
    for (int i = 0; i < 3; i++) add(1, 8'hA5, 0, 4'd1, 19'h7FFFF, 0, run_f, err_f, 5'd2);
  endtask

  initial begin
    logic [7:0]  sum;
    logic [3:0]  ea;
    logic [18:0] ew;
    logic [4:0]  ec;
    logic [18:0] w;
    logic [31:0] prev;
    vec_t        src[$];
    vec_t        gap;
    int unsigned n_img;

    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #12;
    reset = 1'b1;

    // Reset state
    do_reset("reset_values");

    // Two-word load, continuous stream
    build_two_word(8'hAE, 1'b1);
    run_table("two_word");

    // Bad header 0x00, then 0x11; later bytes must not be consumed
    do_reset("reset_before_hdr0");
    add(1, 8'h00, 0, 4'd0, 19'h0, 0, 0, 1, 5'd0);
    add(1, 8'h02, 0, 4'd0, 19'h0, 0, 0, 1, 5'd0);
    add(0, 8'h00, 0, 4'd0, 19'h0, 0, 0, 1, 5'd0);
    run_table("bad_hdr_00");
    do_reset("reset_before_hdr11");
    add(1, 8'h11, 0, 4'd0, 19'h0, 0, 0, 1, 5'd0);
    add(1, 8'h34, 0, 4'd0, 19'h0, 0, 0, 1, 5'd0);
    run_table("bad_hdr_11");

    // Full 16-word image, word k = k * 0x1111
    do_reset("reset_before_full");
    sum = 8'h10;
    ea  = 4'd0;
    ew  = 19'h0;
    ec  = 5'd0;
    add(1, 8'h10, 0, ea, ew, 1, 0, 0, ec);
    for (int k = 0; k < 16; k++) begin
      w = 19'(k * 32'h1111);
      add(1, w[7:0], 0, ea, ew, 1, 0, 0, ec);
      add(1, w[15:8], 0, ea, ew, 1, 0, 0, ec);
      sum = sum + w[7:0] + w[15:8];
      ea = 4'(k);
      ew = w;
      ec = 5'(k + 1);
      add(1, 8'h00, 1, ea, ew, (k == 15) ? CK : 1'b1, 0, 0, ec);
    end
    if (CK) add(1, 8'(8'h00 - sum), 0, ea, ew, 0, 1, 0, ec);
    add(1, 8'h5A, 0, ea, ew, 0, 1, 0, ec);
    add(1, 8'h5A, 0, ea, ew, 0, 1, 0, ec);
    run_table("full_image");

    // Backpressure: 0-3 idle cycles before every image byte after the header
    do_reset("reset_before_bp");
    build_two_word(8'hAE, 1'b1);
    src   = tbl;
    n_img = CK ? 8 : 7;
    tbl.delete();
    for (int i = 0; i < src.size(); i++) begin
      if (i >= 1 && i < int'(n_img)) begin
        prev = src[i-1].exp;
        prev[31] = 1'b0;
        gap.valid = 1'b0;
        gap.data  = 8'h00;
        gap.exp   = prev;
        for (int g = 0; g < int'($urandom_range(0, 3)); g++) tbl.push_back(gap);
      end
      tbl.push_back(src[i]);
    end
    run_table("backpressure");

    // Reset mid-load: after byte 1 of word 1
    do_reset("reset_before_midload");
    build_two_word(8'hAE, 1'b1);
    while (tbl.size() > 6) void'(tbl.pop_back());
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rx_valid = tbl[i].valid;
      rx_data  = tbl[i].data;
      @(posedge clk);
      #1;
      check($sformatf("midload[%0d]", i), outs(), tbl[i].exp);
    end
    tbl.delete();
    #2;
    reset = 1'b0;
    #1;
    check("midload_async_reset", outs(), {1'b0, 4'h0, 19'h0, 1'b1, 1'b0, 1'b0, 5'd0});
    @(posedge clk);
    #1;
    check("midload_reset_held", outs(), {1'b0, 4'h0, 19'h0, 1'b1, 1'b0, 1'b0, 5'd0});
    @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b1;
    build_two_word(8'hAE, 1'b1);
    run_table("after_midload");

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum: words still written, error latched, no release
    do_reset("reset_before_badchk");
    build_two_word(8'h00, 1'b0);
    run_table("bad_checksum");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader placed upstream of the processor core. Accepts a byte stream over a valid/ready link, assembles 19-bit instruction words, and writes them into the 16-entry instruction memory through a dedicated write port. It holds the core idle until the image is complete, then releases it with `core_run`. Malformed images latch a sticky error, and the core is never released.

## Interface
- `DEPTH`, 16, number of instruction memory entries.
- `ADDR_W`, 4, instruction memory address width; `DEPTH` = 2^`ADDR_W`.
- `INSTR_W`, 19, instruction word width.

- `clk` input 1 — single clock; all state updates on the rising edge.
- `reset` input 1 — asynchronous, active-low reset. Asserted (0) clears all state immediately.
- `rx_data` input 8 — stream byte.
- `rx_valid` input 1 — `rx_data` is valid.
- `rx_ready` output 1 — loader accepts a byte. A handshake occurs when `rx_valid` and `rx_ready` are both 1 at a rising edge.
- `imem_we` output 1 — one-cycle write strobe to the instruction memory.
- `imem_addr` output `ADDR_W` — write address, equal to the word index.
- `imem_wdata` output `INSTR_W` — write data.
- `core_run` output 1 — 1 means the core may leave reset and fetch. Sticky until `reset`.
- `load_error` output 1 — 1 means the image was rejected. Sticky until `reset`.
- `word_count` output 5 — number of words written so far (0..16).

## Operation
- **Stream format:** header byte N (word count), then N words of 3 bytes each, least-significant byte first. The assembled 24-bit value keeps bits [18:0]; bits [23:19] are discarded.
- **Valid N:** 1..`DEPTH`. N = 0 or N > `DEPTH` moves to ERROR.
- **States and transitions:**
  - HDR → B0 on a valid header; HDR → ERROR on an invalid header.
  - B0 → B1 → B2, one handshake each.
  - B2 → B0 if words remain.
  - B2 → DONE on the last word (or → CHK when `IMEM_LOADER_CHECKSUM_EN` is defined).
  - CHK → DONE on a good checksum; CHK → ERROR on a bad one.
  - DONE and ERROR are terminal until reset.
- **`rx_ready`:** 1 in HDR, B0, B1, B2 and CHK; 0 in DONE and ERROR. Bytes offered in DONE or ERROR are never consumed.
- **Word writes:** each word's write uses `imem_addr` = index (0..N-1). `word_count` increments in the same cycle as `imem_we`.
- **Untouched entries:** entries N..15 are not written and keep their memory reset contents.
- **Exclusivity:** `core_run` and `load_error` are mutually exclusive.
- **Idle stream:** no timeout; the loader waits indefinitely for `rx_valid`.

## Timing
- **Reset values:** `rx_ready`=1 (state HDR); `imem_we`=0; `imem_addr`=0; `imem_wdata`=0; `core_run`=0; `load_error`=0; `word_count`=0.
- **Reset mid-load:** asynchronous. All outputs drop to their reset values at once and the state returns to HDR. A write already presented is abandoned; the stream must restart with a header.
- **Write latency:** byte-2 handshake at edge T → `imem_we`=1 during cycle T+1, with `imem_addr`/`imem_wdata` registered. The strobe is exactly one cycle.
- **Release, checksum disabled:** final byte-2 handshake at T → `imem_we` during T+1 → `core_run` rises at T+2.
- **Release, checksum enabled:** the last word's write still occurs in the cycle after its byte-2 handshake. Checksum handshake at T' → `core_run` or `load_error` rises at T'+1.
- **Error latency:** bad header handshake at T → `load_error`=1 and `rx_ready`=0 from T+1.
- **Throughput:** one byte per cycle sustained. Gaps in `rx_valid` stall state only; they never change the written data.

## Configuration
- **Macro:** `IMEM_LOADER_CHECKSUM_EN`.
- **Defined:**
  - An 8-bit running sum covers every accepted byte, including the header.
  - After the last word, one checksum byte C is required.
  - The image is accepted if (sum + C) mod 256 = 0; otherwise → ERROR.
  - Words already written stay in memory, but `core_run` never asserts.
- **Undefined:** no CHK state, no sum register; DONE follows the last word directly.

## Test plan
- **Two-word load:** stream 0x02, 0x34, 0x12, 0x05, 0xFF, 0xFF, 0x07 → writes addr0=0x51234 and addr1=0x7FFFF. `word_count`=2; `core_run`=1 two cycles after the final handshake; `rx_ready`=0 afterwards.
- **Bad headers:** header 0x00 → `load_error`=1 next cycle, no `imem_we`. Repeat with header 0x11 → same result.
- **Full image:** N=16, word k = k×0x1111 → 16 writes to addr 0..15 in order; `word_count`=16; `core_run`=1.
- **Backpressure:** random 0–3 idle cycles between bytes of the two-word image → identical writes and release. No byte is accepted in DONE even with `rx_valid`=1.
- **Reset mid-load:** assert `reset` after byte 1 of word 1 → all outputs return to reset values asynchronously. A fresh two-word stream then loads correctly.
- **Checksum (`IMEM_LOADER_CHECKSUM_EN`):** two-word stream plus C=0xAE → `core_run`=1. Same stream with C=0x00 → `load_error`=1, `core_run`=0, and both words still written.
